// File: rtl/pulse_onehot_decoder.sv
// rtl/pulse_onehot_decoder.sv - binary code to timed one-hot strobe with one-entry pending slot
//
// Purpose: takes a line index over a valid/ready handshake and drives the
// matching strobe line high for PULSE_LEN cycles, then holds every line low
// for GAP_LEN cycles. A one-entry pending slot lets the next request be
// taken while a strobe is still running.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   en          block enable; low aborts the current strobe and clears the pending slot
//   code        requested line index
//   code_valid  code is valid this cycle
//   code_ready  a code can be taken this cycle (en and pending slot empty)
//   onehot      registered strobe lines, at most one bit set
//   busy        a strobe or gap is running, or the pending slot is full
//   done        one-cycle pulse in the cycle after a strobe's last high cycle
//   err         one-cycle pulse after an out-of-range code is taken

module pulse_onehot_decoder #(
    parameter int CODE_W    = 3,
    parameter int N_OUT     = 8,
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [CODE_W-1:0] code,
    input  logic              code_valid,
    output logic              code_ready,
    output logic [N_OUT-1:0]  onehot,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int MAX_LEN = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    // Counters load "length - 1" on entry and the state ends when they reach zero.
    localparam logic [CNT_W-1:0]  PULSE_LOAD = CNT_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0]  GAP_LOAD   = CNT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
    localparam logic [CODE_W:0]   N_OUT_V    = (CODE_W + 1)'(N_OUT);
    localparam logic              NO_GAP     = (GAP_LEN == 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_GAP    = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                pend_valid_q, pend_valid_d;
    logic [CODE_W-1:0]   pend_code_q, pend_code_d;
    logic [N_OUT-1:0]    onehot_q, onehot_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic                accept;
    logic                code_in_range;
    logic                take_code;
    logic                cnt_last;
    logic                launch_pt;
    logic                launch_go;
    logic [CODE_W-1:0]   launch_code;

    function automatic logic [N_OUT-1:0] decode(input logic [CODE_W-1:0] c);
        logic [N_OUT-1:0] r;
        r = '0;
        for (int i = 0; i < N_OUT; i++) begin
            r[i] = (c == CODE_W'(i));
        end
        return r;
    endfunction

    assign code_ready    = en & ~pend_valid_q;
    assign accept        = code_valid & code_ready;
    assign code_in_range = ({1'b0, code} < N_OUT_V);
    // Out-of-range codes are taken off the handshake but never stored or launched.
    assign take_code     = accept & code_in_range;
    assign cnt_last      = (cnt_q == '0);

    // Edges where a new strobe may start: any idle edge, the end of the gap,
    // or the end of the strobe itself when there is no gap.
    assign launch_pt = (state_q == S_IDLE)
                     | ((state_q == S_ACTIVE) & cnt_last & NO_GAP)
                     | ((state_q == S_GAP) & cnt_last);

    // The pending slot is older than anything on the input, so it goes first.
    // code_ready is low whenever the slot is full, so both cannot compete.
    assign launch_go   = pend_valid_q | take_code;
    assign launch_code = pend_valid_q ? pend_code_q : code;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pend_valid_d = pend_valid_q;
        pend_code_d  = pend_code_q;
        onehot_d     = onehot_q;
        done_d       = 1'b0;
        err_d        = accept & ~code_in_range;

        if (!en) begin
            state_d      = S_IDLE;
            cnt_d        = '0;
            pend_valid_d = 1'b0;
            onehot_d     = '0;
            err_d        = 1'b0;
        end else begin
            if ((state_q == S_ACTIVE) && cnt_last) begin
                done_d = 1'b1;
            end

            if (launch_pt) begin
                pend_valid_d = 1'b0;
                if (launch_go) begin
                    state_d  = S_ACTIVE;
                    cnt_d    = PULSE_LOAD;
                    onehot_d = decode(launch_code);
                end else begin
                    state_d  = S_IDLE;
                    cnt_d    = '0;
                    onehot_d = '0;
                end
            end else begin
                if (take_code) begin
                    pend_valid_d = 1'b1;
                    pend_code_d  = code;
                end
                case (state_q)
                    S_ACTIVE: begin
                        if (cnt_last) begin
                            state_d  = S_GAP;
                            cnt_d    = GAP_LOAD;
                            onehot_d = '0;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                    S_GAP: begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            pend_valid_q <= 1'b0;
            pend_code_q  <= '0;
            onehot_q     <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pend_valid_q <= pend_valid_d;
            pend_code_q  <= pend_code_d;
            onehot_q     <= onehot_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign onehot = onehot_q;
    assign done   = done_q;
    assign err    = err_q;
    assign busy   = (state_q != S_IDLE) | pend_valid_q;

endmodule

// File: tb/tb_pulse_onehot_decoder.sv
// tb/tb_pulse_onehot_decoder.sv - self-checking bench for pulse_onehot_decoder

module tb_pulse_onehot_decoder;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [2:0] code;
    logic       code_valid;

    logic       ready_a, busy_a, done_a, err_a;
    logic       ready_b, busy_b, done_b, err_b;
    logic       ready_c, busy_c, done_c, err_c;
    logic [7:0] oh_a, oh_b;
    logic [5:0] oh_c;

    int n_checks = 0;
    int n_fail   = 0;

    // A: default timing. B: no gap. C: six lines, short pulse, long gap.
    pulse_onehot_decoder #(.CODE_W(3), .N_OUT(8), .PULSE_LEN(4), .GAP_LEN(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .code(code), .code_valid(code_valid),
        .code_ready(ready_a), .onehot(oh_a), .busy(busy_a), .done(done_a), .err(err_a));
    pulse_onehot_decoder #(.CODE_W(3), .N_OUT(8), .PULSE_LEN(4), .GAP_LEN(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .code(code), .code_valid(code_valid),
        .code_ready(ready_b), .onehot(oh_b), .busy(busy_b), .done(done_b), .err(err_b));
    pulse_onehot_decoder #(.CODE_W(3), .N_OUT(6), .PULSE_LEN(2), .GAP_LEN(3)) dut_c (
        .clk(clk), .rst_n(rst_n), .en(en), .code(code), .code_valid(code_valid),
        .code_ready(ready_c), .onehot(oh_c), .busy(busy_c), .done(done_c), .err(err_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: each job occupies the edges [start, start+P+G); its
    // strobe is visible after edges start..start+P-1 and done after start+P.
    int         cfg_p [3] = '{4, 4, 2};
    int         cfg_g [3] = '{1, 0, 3};
    int         cfg_n [3] = '{8, 8, 6};
    int         edge_no = 0;
    bit         m_act  [3];
    int         m_code [3];
    int         m_start[3];
    bit         m_pv   [3];
    int         m_pc   [3];
    logic [7:0] e_oh   [3];
    bit         e_done [3];
    bit         e_err  [3];
    bit         e_busy [3];

    always @(posedge clk or negedge rst_n) begin
        bit acc, bad, fin;
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                m_act[k] = 0; m_pv[k] = 0; e_oh[k] = 8'h00;
                e_done[k] = 0; e_err[k] = 0; e_busy[k] = 0;
            end
        end else begin
            edge_no++;
            for (int k = 0; k < 3; k++) begin
                e_done[k] = 0;
                e_err[k]  = 0;
                if (!en) begin
                    m_act[k] = 0;
                    m_pv[k]  = 0;
                end else begin
                    acc = code_valid && !m_pv[k];
                    bad = acc && (int'(code) >= cfg_n[k]);
                    fin = m_act[k] && (edge_no == m_start[k] + cfg_p[k] + cfg_g[k]);
                    e_done[k] = m_act[k] && (edge_no == m_start[k] + cfg_p[k]);
                    e_err[k]  = bad;
                    if (!m_act[k] || fin) begin
                        if (m_pv[k]) begin
                            m_act[k] = 1; m_code[k] = m_pc[k]; m_start[k] = edge_no; m_pv[k] = 0;
                        end else if (acc && !bad) begin
                            m_act[k] = 1; m_code[k] = int'(code); m_start[k] = edge_no;
                        end else begin
                            m_act[k] = 0;
                        end
                    end else if (acc && !bad) begin
                        m_pv[k] = 1;
                        m_pc[k] = int'(code);
                    end
                end
                e_oh[k]   = (m_act[k] && (edge_no - m_start[k] < cfg_p[k])) ? 8'(1 << m_code[k]) : 8'h00;
                e_busy[k] = m_act[k] || m_pv[k];
            end
        end
    end

    task automatic idle_cycles(input int n);
        en = 1'b1;
        code_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++; if (oh_a !== 8'h00) begin n_fail++; $display("FAIL reset_onehot got %h want 00", oh_a); end
        n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done_a); end
        n_checks++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err_a); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_a); end
        n_checks++; if (ready_a !== 1'b1) begin n_fail++; $display("FAIL reset_ready_en1 got %b want 1", ready_a); end
        en = 1'b0;
        #1;
        n_checks++; if (ready_a !== 1'b0) begin n_fail++; $display("FAIL reset_ready_en0 got %b want 0", ready_a); end
        en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(2);
    endtask

    task automatic test_single();
        logic [7:0] exp_oh [6] = '{8'h20, 8'h20, 8'h20, 8'h20, 8'h00, 8'h00};
        bit         exp_dn [6] = '{0, 0, 0, 0, 1, 0};
        bit         exp_bs [6] = '{1, 1, 1, 1, 1, 0};
        code = 3'd5; code_valid = 1'b1;
        #1;
        n_checks++; if (ready_a !== 1'b1) begin n_fail++; $display("FAIL single_ready got %b want 1", ready_a); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            code_valid = 1'b0;
            n_checks++; if (oh_a !== exp_oh[i]) begin n_fail++; $display("FAIL single_onehot[%0d] got %h want %h", i, oh_a, exp_oh[i]); end
            n_checks++; if (done_a !== exp_dn[i]) begin n_fail++; $display("FAIL single_done[%0d] got %b want %b", i, done_a, exp_dn[i]); end
            n_checks++; if (busy_a !== exp_bs[i]) begin n_fail++; $display("FAIL single_busy[%0d] got %b want %b", i, busy_a, exp_bs[i]); end
        end
        idle_cycles(3);
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_oh [11] = '{8'h04, 8'h04, 8'h04, 8'h04, 8'h00,
                                    8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h00};
        bit         exp_dn [11] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
        code = 3'd2; code_valid = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            n_checks++; if (oh_a !== exp_oh[i]) begin n_fail++; $display("FAIL b2b_onehot[%0d] got %h want %h", i, oh_a, exp_oh[i]); end
            n_checks++; if (done_a !== exp_dn[i]) begin n_fail++; $display("FAIL b2b_done[%0d] got %b want %b", i, done_a, exp_dn[i]); end
            if (i == 0) begin
                code = 3'd7;
                #1;
                n_checks++; if (ready_a !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_second got %b want 1", ready_a); end
            end else begin
                code_valid = 1'b0;
            end
            if (i == 1) begin
                #1;
                n_checks++; if (ready_a !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_full got %b want 0", ready_a); end
            end
        end
        idle_cycles(12);
    endtask

    task automatic test_gap0();
        code = 3'd1; code_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            code_valid = (i == 0);
            n_checks++;
            if (oh_b !== ((i < 8) ? 8'h02 : 8'h00)) begin
                n_fail++; $display("FAIL gap0_onehot[%0d] got %h want %h", i, oh_b, (i < 8) ? 8'h02 : 8'h00);
            end
            n_checks++;
            if (done_b !== ((i == 4) || (i == 8))) begin
                n_fail++; $display("FAIL gap0_done[%0d] got %b want %b", i, done_b, (i == 4) || (i == 8));
            end
        end
        idle_cycles(12);
    endtask

    task automatic test_invalid();
        code = 3'd6; code_valid = 1'b1;
        #1;
        n_checks++; if (ready_c !== 1'b1) begin n_fail++; $display("FAIL inv_ready got %b want 1", ready_c); end
        @(negedge clk);
        code_valid = 1'b0;
        n_checks++; if (err_c !== 1'b1) begin n_fail++; $display("FAIL inv_err got %b want 1", err_c); end
        n_checks++; if (oh_c !== 6'h00) begin n_fail++; $display("FAIL inv_onehot got %h want 00", oh_c); end
        n_checks++; if (busy_c !== 1'b0) begin n_fail++; $display("FAIL inv_busy got %b want 0", busy_c); end
        n_checks++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL inv_err_wide got %b want 0", err_a); end
        n_checks++; if (oh_a !== 8'h40) begin n_fail++; $display("FAIL inv_onehot_wide got %h want 40", oh_a); end
        @(negedge clk);
        n_checks++; if (err_c !== 1'b0) begin n_fail++; $display("FAIL inv_err_once got %b want 0", err_c); end
        n_checks++; if (busy_c !== 1'b0) begin n_fail++; $display("FAIL inv_busy_after got %b want 0", busy_c); end
        idle_cycles(8);
    endtask

    task automatic test_abort();
        code = 3'd3; code_valid = 1'b1;
        @(negedge clk);
        n_checks++; if (oh_a !== 8'h08) begin n_fail++; $display("FAIL abort_first got %h want 08", oh_a); end
        code = 3'd4;
        @(negedge clk);
        code_valid = 1'b0;
        n_checks++; if (oh_a !== 8'h08) begin n_fail++; $display("FAIL abort_second got %h want 08", oh_a); end
        en = 1'b0;
        #1;
        n_checks++; if (ready_a !== 1'b0) begin n_fail++; $display("FAIL abort_ready_low got %b want 0", ready_a); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (oh_a !== 8'h00) begin n_fail++; $display("FAIL abort_onehot[%0d] got %h want 00", i, oh_a); end
            n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL abort_done[%0d] got %b want 0", i, done_a); end
            n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL abort_busy[%0d] got %b want 0", i, busy_a); end
            n_checks++; if (ready_a !== 1'b0) begin n_fail++; $display("FAIL abort_ready[%0d] got %b want 0", i, ready_a); end
        end
        en = 1'b1;
        #1;
        n_checks++; if (ready_a !== 1'b1) begin n_fail++; $display("FAIL abort_ready_back got %b want 1", ready_a); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++; if (oh_a !== 8'h00) begin n_fail++; $display("FAIL abort_pending_dropped[%0d] got %h want 00", i, oh_a); end
        end
        idle_cycles(2);
    endtask

    task automatic test_async_reset();
        code = 3'd3; code_valid = 1'b1;
        @(negedge clk);
        code_valid = 1'b0;
        n_checks++; if (oh_a !== 8'h08) begin n_fail++; $display("FAIL arst_before got %h want 08", oh_a); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (oh_a !== 8'h00) begin n_fail++; $display("FAIL arst_onehot got %h want 00", oh_a); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL arst_busy got %b want 0", busy_a); end
        @(negedge clk);
        rst_n = 1'b1;
        code = 3'd0; code_valid = 1'b1;
        @(negedge clk);
        code_valid = 1'b0;
        n_checks++; if (oh_a !== 8'h01) begin n_fail++; $display("FAIL arst_relaunch got %h want 01", oh_a); end
        n_checks++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL arst_done got %b want 0", done_a); end
        idle_cycles(10);
    endtask

    task automatic test_random();
        logic [7:0] d_oh [3];
        logic       d_dn [3];
        logic       d_er [3];
        logic       d_bs [3];
        logic       d_rd [3];
        for (int cyc = 0; cyc < 1500; cyc++) begin
            d_oh = '{oh_a, oh_b, {2'b00, oh_c}};
            d_dn = '{done_a, done_b, done_c};
            d_er = '{err_a, err_b, err_c};
            d_bs = '{busy_a, busy_b, busy_c};
            for (int k = 0; k < 3; k++) begin
                n_checks++; if (d_oh[k] !== e_oh[k]) begin n_fail++; $display("FAIL rnd_onehot dut%0d cyc%0d got %h want %h", k, cyc, d_oh[k], e_oh[k]); end
                n_checks++; if (d_dn[k] !== e_done[k]) begin n_fail++; $display("FAIL rnd_done dut%0d cyc%0d got %b want %b", k, cyc, d_dn[k], e_done[k]); end
                n_checks++; if (d_er[k] !== e_err[k]) begin n_fail++; $display("FAIL rnd_err dut%0d cyc%0d got %b want %b", k, cyc, d_er[k], e_err[k]); end
                n_checks++; if (d_bs[k] !== e_busy[k]) begin n_fail++; $display("FAIL rnd_busy dut%0d cyc%0d got %b want %b", k, cyc, d_bs[k], e_busy[k]); end
            end
            en         = ($urandom_range(0, 19) != 0);
            code_valid = ($urandom_range(0, 2) != 0);
            code       = 3'($urandom_range(0, 7));
            #1;
            d_rd = '{ready_a, ready_b, ready_c};
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (d_rd[k] !== (en && !m_pv[k])) begin
                    n_fail++; $display("FAIL rnd_ready dut%0d cyc%0d got %b want %b", k, cyc, d_rd[k], en && !m_pv[k]);
                end
            end
            @(negedge clk);
        end
        idle_cycles(2);
    endtask

    initial begin
        rst_n      = 1'b0;
        en         = 1'b1;
        code       = 3'd0;
        code_valid = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_gap0();
        test_invalid();
        test_abort();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
